fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline. It holds the PC, issues one outstanding request at a time to instruction memory, and absorbs stalls with a one-entry skid buffer. It applies branch/jump redirects and drives the IF/ID register whose `id_inst` output feeds the decoder directly. When no instruction is valid, it presents a NOP (32'h0000_0000, `sll $0,$0,0`), so the decoder needs no valid qualifier.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request, valid for one address.
- `imem_addr`  out  32  word-aligned fetch address; bits [1:0] always 0.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `stall`  in  1  hazard unit: hold IF/ID contents.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_inst`  out  32  instruction to decoder; 0 when `id_valid`=0.
- `id_pc`  out  32  address of `id_inst`.
- `id_pc_plus4`  out  32  `id_pc`+4, modulo 2^32.

## Operation
The stage is a four-state FSM: FETCH, WAIT, HOLD, DROP. The registers are `pc` (next fetch address), `pc_req` (address in flight), and the skid buffer (`skid_inst`, `skid_pc`).

- Reset:
  - `pc`←`RESET_PC`; the FSM goes to FETCH.
  - `id_valid`, `id_inst`, `id_pc` and `id_pc_plus4` all ←0.
  - `imem_req`=0 during every cycle in which `rst`=1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, unless `redirect_valid`=1; in that case `imem_req`=0 and `pc`←{`redirect_pc`[31:2],2'b00}.
  - If `imem_req` & `imem_ready`: `pc_req`←`pc`, `pc`←`pc`+4, next state WAIT.
- WAIT:
  - On `redirect_valid` without `imem_rvalid`: `pc`←redirect, next state DROP.
  - On `redirect_valid` with `imem_rvalid`: the data is discarded and `pc`←redirect; next state FETCH.
  - On `imem_rvalid` & ~`stall`: IF/ID←(`imem_rdata`, `pc_req`); next state FETCH.
  - On `imem_rvalid` & `stall`: skid←(`imem_rdata`, `pc_req`); next state HOLD.
- HOLD:
  - On `redirect_valid`: the skid buffer is discarded and `pc`←redirect; next state FETCH.
  - Otherwise, on ~`stall`: IF/ID←skid; next state FETCH.
- DROP:
  - On `imem_rvalid`: the data is discarded; next state FETCH.
  - On `redirect_valid`: `pc`←redirect and the FSM stays in DROP (the same cycle as `imem_rvalid` still exits to FETCH with the new `pc`).
- IF/ID update priority: `rst` > `redirect_valid` (flush: `id_valid`←0, `id_inst`←0) > `stall` (hold) > load > bubble.
  - Load sets `id_valid`←1 and `id_pc_plus4`←`id_pc`+4.
  - Bubble (no load, no stall) sets `id_valid`←0 and `id_inst`←0.
- `imem_rvalid` outside WAIT/DROP is ignored.
- `pc`+4 wraps 32'hFFFF_FFFC→0.

## Timing
- At most one request is outstanding. Peak throughput is one instruction per 2 cycles (FETCH accept, WAIT return).
- The `redirect_valid`→`imem_req` path is combinational (gating only). All other outputs are registered.
- Minimum latency is 2 cycles from FETCH accept to `id_valid`: accept in cycle 0, `imem_rvalid` in cycle 1, `id_valid`=1 in cycle 2.
- `stall` and `redirect_valid` take effect on the IF/ID register at the same edge at which they are sampled.
- An arbitrary `imem_ready`/`imem_rvalid` delay is tolerated; FETCH and WAIT hold indefinitely.
- Reset mid-operation: the in-flight response after reset arrives while the FSM is in FETCH. The design requires memory to cancel it on `rst`, so responses are never matched to the wrong request.

## Structure
- Shared package (`defines` header):
  - `InstDataWidth`, `InstAddrWidth`, `RstEnable`.
  - `NopInst`=32'h0.
  - Fetch FSM state encoding (FETCH/WAIT/HOLD/DROP, 2 bits).
- Sub-module `if_id_reg` is the IF/ID pipeline register. It has inputs load, stall, flush and data, and outputs `id_*`. It applies the priority order above.

## Test plan
- Reset then free run, `imem_ready`=1, `rvalid` one cycle after accept → `imem_addr` sequence 0,4,8; `id_inst` shows the loaded words on cycles 2,4,6; `id_pc_plus4`=`id_pc`+4.
- `stall` high for 3 cycles while the response for address 0x8 returns → FSM enters HOLD, `imem_req`=0, and IF/ID holds the previous instruction. On release, `id_pc`=0x8 with the correct data, and the next `imem_addr`=0xC.
- `redirect_valid` with `redirect_pc`=0x0040_0103 in WAIT → the response is discarded in DROP, `id_valid`=0 and `id_inst`=0. The next fetch address is 0x0040_0100.
- `redirect_valid` and `stall` in the same cycle with `id_valid`=1 → the next cycle shows `id_valid`=0 and `id_inst`=0 (flush wins).
- `RESET_PC`=32'hFFFF_FFFC → fetch 0xFFFF_FFFC, then 0x0, with `id_pc_plus4`=0.
- Assert `rst` during WAIT → the next cycle `id_valid`=0 and `imem_req`=0; after release, the first `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: widths, NOP encoding,
// fetch FSM state encoding and the word-alignment helper.
package fetch_stage_pkg;

  localparam int InstDataWidth = 32;
  localparam int InstAddrWidth = 32;
  localparam logic RstEnable = 1'b1;

  localparam logic [InstDataWidth-1:0] NopInst = 32'h0000_0000;
  localparam logic [InstAddrWidth-1:0] PcStep  = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_DROP  = 2'b11
  } fetch_state_e;

  function automatic logic [InstAddrWidth-1:0] align_pc(input logic [InstAddrWidth-1:0] addr);
    return {addr[InstAddrWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall (hold) > load > bubble.
// A flush or bubble clears valid and forces the NOP so the decoder needs no qualifier.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [InstDataWidth-1:0] load_inst,
  input  logic [InstAddrWidth-1:0] load_pc,
  output logic                     id_valid,
  output logic [InstDataWidth-1:0] id_inst,
  output logic [InstAddrWidth-1:0] id_pc,
  output logic [InstAddrWidth-1:0] id_pc_plus4
);

  logic                     valid_d, valid_q;
  logic [InstDataWidth-1:0] inst_d, inst_q;
  logic [InstAddrWidth-1:0] pc_d, pc_q;
  logic [InstAddrWidth-1:0] pc4_d, pc4_q;

  // Next IF/ID contents in priority order; the pc fields survive flush and bubble.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = NopInst;
    end else if (stall) begin
      valid_d = valid_q;
      inst_d  = inst_q;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = load_inst;
      pc_d    = load_pc;
      pc4_d   = load_pc + PcStep;
    end else begin
      valid_d = 1'b0;
      inst_d  = NopInst;
    end
  end

  // IF/ID state register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      inst_q  <= NopInst;
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_inst     = inst_q;
  assign id_pc       = pc_q;
  assign id_pc_plus4 = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, one-entry skid buffer
// for stalls, redirect handling, and the IF/ID register feeding the decoder.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  fetch_state_e             state_d, state_q;
  logic [InstAddrWidth-1:0] pc_d, pc_q;
  logic [InstAddrWidth-1:0] pc_req_d, pc_req_q;
  logic [InstDataWidth-1:0] skid_inst_d, skid_inst_q;
  logic [InstAddrWidth-1:0] skid_pc_d, skid_pc_q;
  logic [InstAddrWidth-1:0] redirect_aligned_s;
  logic                     req_s;
  logic                     load_s;
  logic [InstDataWidth-1:0] load_inst_s;
  logic [InstAddrWidth-1:0] load_pc_s;

  assign redirect_aligned_s = align_pc(redirect_pc);

  // Fetch FSM next state, pc bookkeeping, skid capture and IF/ID load request.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_req_d    = pc_req_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    req_s       = 1'b0;
    load_s      = 1'b0;
    load_inst_s = NopInst;
    load_pc_s   = pc_req_q;
    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned_s;
        end else begin
          req_s = 1'b1;
          if (imem_ready) begin
            pc_req_d = pc_q;
            pc_d     = pc_q + PcStep;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // A response arriving with the redirect is dropped on the spot.
          pc_d    = redirect_aligned_s;
          state_d = imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (imem_rvalid) begin
          if (stall) begin
            skid_inst_d = imem_rdata;
            skid_pc_d   = pc_req_q;
            state_d     = ST_HOLD;
          end else begin
            load_s      = 1'b1;
            load_inst_s = imem_rdata;
            load_pc_s   = pc_req_q;
            state_d     = ST_FETCH;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_aligned_s;
          state_d = ST_FETCH;
        end else if (!stall) begin
          load_s      = 1'b1;
          load_inst_s = skid_inst_q;
          load_pc_s   = skid_pc_q;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rvalid) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= ST_FETCH;
      pc_q        <= align_pc(RESET_PC);
      pc_req_q    <= 32'h0000_0000;
      skid_inst_q <= NopInst;
      skid_pc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_req_q    <= pc_req_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign imem_req  = req_s & ~rst;
  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load_s),
    .stall       (stall),
    .flush       (redirect_valid),
    .load_inst   (load_inst_s),
    .load_pc     (load_pc_s),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

endmodule
